// File: rtl/fp_mul_const_vec.sv
// Multi-lane FP32-style multiply-by-constant unit with round-to-nearest-even.
// Two-stage valid/ready pipeline: S1 captures operands/mode, S2 normalises, rounds and registers results.
module fp_mul_const_vec #(
    parameter int              LANES      = 4,
    parameter int              EXPO_WIDTH = 8,
    parameter int              MANT_WIDTH = 23,
    parameter logic [MANT_WIDTH:0] C0_MANT = 24'hB8AA3B,
    parameter int              C0_EXP     = 0,
    parameter logic [MANT_WIDTH:0] C1_MANT = 24'hB17218,
    parameter int              C1_EXP     = -1,
    parameter logic [MANT_WIDTH:0] C2_MANT = 24'h800000,
    parameter int              C2_EXP     = 0,
    parameter logic [MANT_WIDTH:0] C3_MANT = 24'h800000,
    parameter int              C3_EXP     = -1
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           in_valid,
    output logic                                           in_ready,
    input  logic [1:0]                                     in_mode,
    input  logic [LANES*(1+EXPO_WIDTH+MANT_WIDTH)-1:0]     in_data,
    output logic                                           out_valid,
    input  logic                                           out_ready,
    output logic [LANES*(1+EXPO_WIDTH+MANT_WIDTH)-1:0]     out_data,
    output logic [2:0]                                     out_flags
);

    localparam int M  = MANT_WIDTH;
    localparam int E  = EXPO_WIDTH;
    localparam int DW = 1 + E + M;
    localparam int PW = 2 * M + 2;
    localparam int XW = E + 2;

    function automatic logic [M:0] const_mant(input logic [1:0] mode);
        case (mode)
            2'd0:    const_mant = C0_MANT;
            2'd1:    const_mant = C1_MANT;
            2'd2:    const_mant = C2_MANT;
            default: const_mant = C3_MANT;
        endcase
    endfunction

    function automatic logic signed [XW-1:0] const_exp(input logic [1:0] mode);
        case (mode)
            2'd0:    const_exp = XW'(C0_EXP);
            2'd1:    const_exp = XW'(C1_EXP);
            2'd2:    const_exp = XW'(C2_EXP);
            default: const_exp = XW'(C3_EXP);
        endcase
    endfunction

    logic                  s1_vld_r;
    logic [1:0]            s1_mode_r;
    logic [LANES*DW-1:0]   s1_data_r;
    logic                  out_vld_r;
    logic [LANES*DW-1:0]   out_data_r;
    logic [2:0]            out_flags_r;
    logic                  out_adv_s;
    logic                  s1_load_s;
    logic [LANES*DW-1:0]   lane_res_s;
    logic [2:0]            lane_flg_s [LANES];
    logic [2:0]            flags_or_s;

    assign out_adv_s = !out_vld_r || out_ready;
    assign s1_load_s = !s1_vld_r || out_adv_s;
    assign in_ready  = s1_load_s;
    assign out_valid = out_vld_r;
    assign out_data  = out_data_r;
    assign out_flags = out_flags_r;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [DW-1:0]          op_s;
        logic                   sgn_s;
        logic [E-1:0]           ef_s;
        logic [M-1:0]           mf_s;
        logic [PW-1:0]          prod_s;
        logic [PW-1:0]          pn_s;
        logic [M-1:0]           mant_s;
        logic                   rnd_s;
        logic [M:0]             mant_rnd_s;
        logic signed [XW-1:0]   eout_s;
        logic [DW-1:0]          res_s;
        logic [2:0]             flg_s;

        assign op_s   = s1_data_r[g*DW +: DW];
        assign sgn_s  = op_s[DW-1];
        assign ef_s   = op_s[DW-2:M];
        assign mf_s   = op_s[M-1:0];
        assign prod_s = PW'({1'b1, mf_s}) * PW'(const_mant(s1_mode_r));
        // Align the leading one to the top bit so one rounding path serves both product ranges.
        assign pn_s   = prod_s[PW-1] ? prod_s : {prod_s[PW-2:0], 1'b0};
        assign mant_s = pn_s[PW-2:M+1];
        assign rnd_s  = pn_s[M] & ((|pn_s[M-1:0]) | mant_s[0]);
        assign mant_rnd_s = {1'b0, mant_s} + {{M{1'b0}}, rnd_s};
        assign eout_s = $signed({2'b00, ef_s}) + const_exp(s1_mode_r)
                      + $signed({{(XW-1){1'b0}}, prod_s[PW-1]})
                      + $signed({{(XW-1){1'b0}}, mant_rnd_s[M]});

        // Special-case priority: NaN, Inf, zero/subnormal input, overflow, underflow, normal.
        always_comb begin
            res_s = {DW{1'b0}};
            flg_s = 3'b000;
            if ((ef_s == {E{1'b1}}) && (mf_s != {M{1'b0}})) begin
                res_s = {sgn_s, {E{1'b1}}, 1'b1, mf_s[M-2:0]};
                flg_s = 3'b100;
            end else if (ef_s == {E{1'b1}}) begin
                res_s = {sgn_s, {E{1'b1}}, {M{1'b0}}};
            end else if (ef_s == {E{1'b0}}) begin
                res_s = {sgn_s, {(DW-1){1'b0}}};
            end else if (eout_s >= $signed({2'b00, {E{1'b1}}})) begin
                res_s = {sgn_s, {E{1'b1}}, {M{1'b0}}};
                flg_s = 3'b010;
            end else if (eout_s <= $signed({XW{1'b0}})) begin
                res_s = {sgn_s, {(DW-1){1'b0}}};
                flg_s = 3'b001;
            end else begin
                res_s = {sgn_s, eout_s[E-1:0], mant_rnd_s[M-1:0]};
            end
        end

        assign lane_res_s[g*DW +: DW] = res_s;
        assign lane_flg_s[g]          = flg_s;
    end

    // OR-reduce per-lane exception flags for the beat.
    always_comb begin
        flags_or_s = 3'b000;
        for (int i = 0; i < LANES; i++) begin
            flags_or_s = flags_or_s | lane_flg_s[i];
        end
    end

    // Pipeline registers: each stage loads when empty or when its successor advances.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld_r    <= 1'b0;
            s1_mode_r   <= 2'b00;
            s1_data_r   <= {(LANES*DW){1'b0}};
            out_vld_r   <= 1'b0;
            out_data_r  <= {(LANES*DW){1'b0}};
            out_flags_r <= 3'b000;
        end else begin
            if (s1_load_s) begin
                s1_vld_r <= in_valid;
                if (in_valid) begin
                    s1_mode_r <= in_mode;
                    s1_data_r <= in_data;
                end
            end
            if (out_adv_s) begin
                out_vld_r <= s1_vld_r;
                if (s1_vld_r) begin
                    out_data_r  <= lane_res_s;
                    out_flags_r <= flags_or_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_const_vec.sv
// Self-checking bench for fp_mul_const_vec: directed spec vectors, random streams with
// backpressure against an integer-arithmetic reference model, mode switching and mid-flight reset.
module tb_fp_mul_const_vec;

    localparam int LANES = 4;
    localparam int DW    = 32;
    localparam int BW    = LANES * DW;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [1:0]     in_mode = 2'b00;
    logic [BW-1:0]  in_data = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [BW-1:0]  out_data;
    logic [2:0]     out_flags;

    int n_pass   = 0;
    int n_fail   = 0;
    int n_checks = 0;

    always #5 clk = ~clk;

    fp_mul_const_vec dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags)
    );

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer product, rounded to nearest-even by comparing the remainder with half an ulp.
    function automatic void model_lane(input logic [31:0] x, input logic [1:0] mode,
                                       output logic [31:0] y, output logic [2:0] fl);
        longint unsigned cm, sig, p, q, rem, half;
        int ce, msb, sh, e;
        case (mode)
            2'd0: begin cm = 64'hB8AA3B; ce = 0;  end
            2'd1: begin cm = 64'hB17218; ce = -1; end
            2'd2: begin cm = 64'h800000; ce = 0;  end
            default: begin cm = 64'h800000; ce = -1; end
        endcase
        fl = 3'b000;
        y  = 32'h0;
        if (x[30:23] == 8'hFF && x[22:0] != 23'h0) begin
            y = {x[31], 8'hFF, 1'b1, x[21:0]};
            fl = 3'b100;
        end else if (x[30:23] == 8'hFF) begin
            y = {x[31], 8'hFF, 23'h0};
        end else if (x[30:23] == 8'h00) begin
            y = {x[31], 31'h0};
        end else begin
            sig = longint'({1'b1, x[22:0]});
            p = sig * cm;
            msb = 0;
            for (int k = 0; k < 48; k++) if (p[k]) msb = k;
            sh = msb - 23;
            q = p >> sh;
            rem = p - (q << sh);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q++;
            e = int'(x[30:23]) + ce + (msb - 46);
            if (q == (64'd1 << 24)) begin
                q = q >> 1;
                e++;
            end
            if (e >= 255) begin
                y = {x[31], 8'hFF, 23'h0};
                fl = 3'b010;
            end else if (e <= 0) begin
                y = {x[31], 31'h0};
                fl = 3'b001;
            end else begin
                y = {x[31], e[7:0], q[22:0]};
            end
        end
    endfunction

    function automatic void model_beat(input logic [BW-1:0] d, input logic [1:0] mode,
                                       output logic [BW-1:0] y, output logic [2:0] fl);
        logic [31:0] ly;
        logic [2:0]  lf;
        fl = 3'b000;
        y  = '0;
        for (int i = 0; i < LANES; i++) begin
            model_lane(d[i*DW +: DW], mode, ly, lf);
            y[i*DW +: DW] = ly;
            fl = fl | lf;
        end
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(3, 0) != 0) w[30:23] = 8'($urandom_range(154, 100));
        return w;
    endfunction

    function automatic logic [BW-1:0] rand_beat();
        logic [BW-1:0] d;
        for (int i = 0; i < LANES; i++) d[i*DW +: DW] = rand_op();
        return d;
    endfunction

    task automatic directed(input string tag, input int lane, input logic [31:0] val,
                            input logic [1:0] mode, input logic [31:0] exp_lane, input logic [2:0] exp_fl);
        logic [BW-1:0] d, y;
        logic [2:0]    fl;
        for (int i = 0; i < LANES; i++) d[i*DW +: DW] = 32'h3F800000;
        d[lane*DW +: DW] = val;
        model_beat(d, mode, y, fl);
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = d; in_mode = mode; out_ready = 1'b1;
        #1;
        check({tag, " in_ready"}, BW'(in_ready), BW'(1'b1));
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = rand_beat();
        #1;
        check({tag, " valid_c1"}, BW'(out_valid), BW'(1'b0));
        @(posedge clk); #2;
        check({tag, " valid_c2"}, BW'(out_valid), BW'(1'b1));
        check({tag, " lane"}, BW'(out_data[lane*DW +: DW]), BW'(exp_lane));
        check({tag, " flags"}, BW'(out_flags), BW'(exp_fl));
        check({tag, " model_data"}, out_data, y);
        check({tag, " model_flags"}, BW'(out_flags), BW'(fl));
    endtask

    task automatic stream(input string tag, input logic [BW-1:0] dq[$], input logic [1:0] mq[$],
                          input bit toggle, output logic [BW-1:0] got[$]);
        logic [BW-1:0] expq[$];
        logic [2:0]    expf[$];
        logic [BW-1:0] held, y, ed;
        logic [2:0]    fl, ef;
        int n, sent, inflight, cyc;
        bit stall_prev, exp_rdy;
        n = dq.size(); sent = 0; inflight = 0; cyc = 0; stall_prev = 1'b0; held = '0;
        got = {};
        while ((sent < n || inflight != 0) && cyc < 200) begin
            @(posedge clk); #1;
            out_ready = toggle ? (cyc % 3 == 0) : 1'b1;
            if (sent < n) begin
                in_valid = 1'b1; in_data = dq[sent]; in_mode = mq[sent];
            end else begin
                in_valid = 1'b0; in_data = rand_beat(); in_mode = 2'($urandom);
            end
            #1;
            if (stall_prev) begin
                check({tag, " stall_valid"}, BW'(out_valid), BW'(1'b1));
                check({tag, " stall_data"}, out_data, held);
            end
            if (inflight == 0) check({tag, " idle_valid"}, BW'(out_valid), BW'(1'b0));
            exp_rdy = !(inflight == 2 && !out_ready);
            check({tag, " in_ready"}, BW'(in_ready), BW'(exp_rdy));
            if (out_valid && out_ready && expq.size() > 0) begin
                ed = expq.pop_front();
                ef = expf.pop_front();
                check({tag, " data"}, out_data, ed);
                check({tag, " flags"}, BW'(out_flags), BW'(ef));
                got.push_back(out_data);
                inflight--;
            end
            stall_prev = out_valid && !out_ready;
            held = out_data;
            if (in_valid && in_ready) begin
                model_beat(dq[sent], mq[sent], y, fl);
                expq.push_back(y);
                expf.push_back(fl);
                sent++;
                inflight++;
            end
            cyc++;
        end
        check({tag, " completed"}, BW'(sent == n && inflight == 0), BW'(1'b1));
        check({tag, " count"}, BW'(got.size()), BW'(n));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BW-1:0] dq[$];
        logic [1:0]    mq[$];
        logic [BW-1:0] got[$];
        logic [BW-1:0] beat;
        logic [31:0]   mode_exp [4];
        mode_exp = '{32'h3FB8AA3B, 32'h3F317218, 32'h3F800000, 32'h3F000000};

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", BW'(out_valid), BW'(1'b0));
        check("reset out_data", out_data, '0);
        check("reset out_flags", BW'(out_flags), BW'(3'b000));
        rst_n = 1'b1;
        #1;
        check("reset in_ready", BW'(in_ready), BW'(1'b1));

        directed("one_log2e", 0, 32'h3F800000, 2'd0, 32'h3FB8AA3B, 3'b000);
        directed("two_ln2",   1, 32'h40000000, 2'd1, 32'h3FB17218, 3'b000);
        directed("rne_norm",  2, 32'h3FC00000, 2'd0, 32'h400A7FAC, 3'b000);
        directed("overflow",  3, 32'h7F7FFFFF, 2'd0, 32'h7F800000, 3'b010);
        directed("underflow", 0, 32'h00800000, 2'd3, 32'h00000000, 3'b001);
        directed("nan",       0, 32'hFFC00001, 2'd0, 32'hFFC00001, 3'b100);
        directed("neg_zero",  0, 32'h80000000, 2'd0, 32'h80000000, 3'b000);
        directed("inf",       2, 32'hFF800000, 2'd1, 32'hFF800000, 3'b000);

        dq = {}; mq = {};
        for (int k = 0; k < 8; k++) begin
            dq.push_back(rand_beat());
            mq.push_back(2'($urandom));
        end
        stream("bp_stream", dq, mq, 1'b1, got);

        dq = {}; mq = {};
        for (int i = 0; i < LANES; i++) beat[i*DW +: DW] = 32'h3F800000;
        for (int k = 0; k < 4; k++) begin
            dq.push_back(beat);
            mq.push_back(2'(k));
        end
        stream("mode_seq", dq, mq, 1'b0, got);
        for (int k = 0; k < 4 && k < got.size(); k++) begin
            check("mode_seq lane0", BW'(got[k][31:0]), BW'(mode_exp[k]));
        end

        // Fill both stages under stall, then reset.
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; in_data = rand_beat(); in_mode = 2'd0;
        @(posedge clk); #1;
        in_data = rand_beat();
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1;
        check("full in_ready", BW'(in_ready), BW'(1'b0));
        check("full out_valid", BW'(out_valid), BW'(1'b1));
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("midrst out_valid", BW'(out_valid), BW'(1'b0));
        check("midrst out_data", out_data, '0);
        check("midrst out_flags", BW'(out_flags), BW'(3'b000));
        check("midrst in_ready", BW'(in_ready), BW'(1'b1));
        @(posedge clk); #2;
        check("midrst no_stale", BW'(out_valid), BW'(1'b0));
        directed("post_rst", 1, 32'h3FC00000, 2'd2, 32'h3FC00000, 3'b000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fp_mul_const_vec.md
Name: fp_mul_const_vec

Overview:
- Multi-lane FP32-style multiply-by-constant unit; the successor to the single-lane fixed log2(e) scaler.
- Scales LANES packed floating-point operands by one of four parameterised constants, chosen per beat by a mode input.
- Uses a true multiply with round-to-nearest-even, not a truncated shift-add.
- Full IEEE special-case handling, 2-stage valid/ready pipeline with backpressure. Sits in front of the exp2/softmax datapath.

Parameters:
- LANES, 4, number of independent operands per beat
- EXPO_WIDTH, 8, exponent field width
- MANT_WIDTH, 23, stored mantissa width; DATA_WIDTH = 1+EXPO_WIDTH+MANT_WIDTH (derived)
- C0_MANT, 24'hB8AA3B, constant 0 significand incl. hidden bit (log2 e); C0_EXP, 0, signed unbiased exponent
- C1_MANT, 24'hB17218, constant 1 significand (ln 2); C1_EXP, -1
- C2_MANT, 24'h800000, constant 2 (1.0); C2_EXP, 0
- C3_MANT, 24'h800000, constant 3 (0.5); C3_EXP, -1

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  unit accepts beat this cycle
- in_mode  in  2  constant select, sampled with the beat
- in_data  in  LANES*DATA_WIDTH  operands, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts
- out_data  out  LANES*DATA_WIDTH  scaled results, same lane packing
- out_flags  out  3  {invalid, overflow, underflow}, OR across lanes, aligned with out_data

Behaviour:
- Reset (rst_n=0 at a clk edge): both stage valid bits cleared; out_valid=0, out_data=0, out_flags=0.
  - in_ready=1 as soon as rst_n=1.
  - In-flight beats are discarded; no partial beat ever emerges.
- Pipeline: S1 registers operands and mode and forms the (M+1)x(M+1) product. S2 normalises, rounds and registers out_data/out_flags.
  - Latency 2 cycles from accepted beat to out_valid.
  - Throughput 1 beat/cycle while out_ready=1.
- Handshake:
  - Transfer occurs on valid&&ready at the clk edge.
  - Each stage loads when it is empty or its successor advances. in_ready = !s1_vld || (!out_valid || out_ready).
  - out_valid held and out_data/out_flags stable while out_ready=0.
  - Simultaneous accept and drain in the same cycle is lossless.
  - in_data is don't-care when in_valid=0.
- Per-lane arithmetic:
  - sign_out = sign_in (all constants positive). P = {1,mant} * C_MANT, width 2M+2.
  - If P[2M+1]=1: shift right 1 and increment exponent.
  - Round to nearest, ties to even, on the discarded bits. If rounding carries out, renormalise: significand=1.0, exponent+1.
  - Exponent: e_out = e_in + C_EXP (+ norm/round increments), computed in EXPO_WIDTH+2 signed bits.
- Special cases, in priority order:
  1. NaN in → quiet NaN out: same sign, mantissa MSB set, payload otherwise kept; invalid=1.
  2. Inf in → Inf, same sign.
  3. Exponent field 0 (zero/subnormal) → signed zero, with no flag.
  4. e_out ≥ all-ones → signed Inf; overflow=1.
  5. e_out ≤ 0 → signed zero (flush to zero); underflow=1.
- Lanes are fully independent. Flags are OR-reduced across lanes and registered with the same beat.
- The mode is captured per beat; a mode change between consecutive beats takes effect with no bubble.

Test Plan:
- Lane0=0x3F800000, mode 0 → lane0 out 0x3FB8AA3B, flags 000, out_valid exactly 2 cycles after accept.
- Lane1=0x40000000, mode 1 → 0x3FB17218. Lane2=0x3FC00000 (1.5), mode 0 → 0x400A7FAC (checks rounding and the normalise shift).
- Lane3=0x7F7FFFFF, mode 0 → 0x7F800000, overflow=1. Lane0=0x00800000, mode 3 → 0x00000000, underflow=1. 0xFFC00001 → 0xFFC00001, invalid=1. 0x80000000 → 0x80000000, flags 000.
- Stream 8 back-to-back beats with out_ready toggling 1,0,0,1,…:
  - no beat is lost or duplicated, and order is preserved;
  - in_ready drops only when both stages are full;
  - out_data is stable during stalls.
- Alternate the mode 0,1,2,3 each cycle on 0x3F800000 → outputs 0x3FB8AA3B, 0x3F317218, 0x3F800000, 0x3F000000 in order.
- Assert rst_n=0 for 1 cycle with both stages full and out_ready=0 → next cycle out_valid=0, out_data=0, in_ready=1; first post-reset beat emerges after 2 cycles.
